controller_shared_memory: RTL and testbench
===========================================

# controller_shared_memory

Parametrised on-chip memory for the controller subsystem: one single-port RAM array shared by two Avalon-MM slave ports (s1: instruction master, s2: data/debug master). It has a round-robin arbiter, pipelined reads with `readdatavalid`, an optional output register stage, and write protection gated by `debugaccess`. It is the drop-in successor for fixed-size dual-port program memories. It trades true dual-port RAM for arbitration so that it can map to any block RAM type, and it adds variable-latency handshaking.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 13: word address width; depth = 2**ADDR_WIDTH.
- `OUTPUT_REG`, 0: 0 gives read latency 1; 1 gives read latency 2 (registered `readdata`).
- `WRITE_PROTECT`, 1: 1 means writes are accepted only with `debugaccess`=1; 0 means all writes are accepted.
- `INIT_FILE`, "controller_shared_memory.hex": array initialisation file.
- `clk`  in  1  single clock for everything.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s1_address`, `s2_address`  in  ADDR_WIDTH  word address.
- `s1_byteenable`, `s2_byteenable`  in  DATA_WIDTH/8  write byte lanes.
- `s1_read`, `s2_read`  in  1  read request.
- `s1_write`, `s2_write`  in  1  write request.
- `s1_writedata`, `s2_writedata`  in  DATA_WIDTH  write data.
- `s1_debugaccess`, `s2_debugaccess`  in  1  write-enable qualifier when WRITE_PROTECT=1.
- `s1_waitrequest`, `s2_waitrequest`  out  1  request not accepted this cycle.
- `s1_readdata`, `s2_readdata`  out  DATA_WIDTH  read data.
- `s1_readdatavalid`, `s2_readdatavalid`  out  1  one-cycle pulse qualifying `readdata`.
- `protect_violation`  out  1  one-cycle pulse when a write is blocked by protection.

## Operation
- A request on port n is `sn_read | sn_write`. Asserting both `read` and `write` is illegal. The bench asserts on it, and the RTL treats it as a write.
- Arbitration:
  - If only one port requests, it is granted.
  - If both request, the port not granted most recently wins. The `last_grant` register updates only on a grant.
  - The losing port sees `waitrequest`=1 and must hold its request stable.
- `waitrequest` is combinational: `sn_waitrequest = request_n & ~grant_n`. With no request it is 0.
- A granted write commits the enabled byte lanes at the clock edge. If WRITE_PROTECT=1 and `debugaccess`=0:
  - no bytes change;
  - `protect_violation` pulses on the next cycle;
  - the transfer is still accepted (`waitrequest`=0).
- A granted read issues to the array at the edge. A port-tag and valid pipeline of depth 1+OUTPUT_REG routes the returned data. Only the issuing port's `readdatavalid` pulses.
- Both ports may have reads in flight back-to-back. Returns are in issue order and never overlap on one port.
- Read-during-write: one port per cycle, so no same-cycle conflict. A read issued the cycle after a write to the same address returns the new data.
- `sn_readdata` holds its last value between valid pulses. It is shared from the array/output register; only the valid signal is demultiplexed.

## Timing
- Reset values:
  - `sn_readdatavalid`=0 and `protect_violation`=0.
  - Output register = 0 and the tag pipeline is cleared.
  - `last_grant`=s2, so s1 wins the first tie.
  - Array contents are not reset; they keep the INIT_FILE or last-written data.
- Read latency, from the accepted edge to the valid pulse: 1 cycle with OUTPUT_REG=0, 2 cycles with OUTPUT_REG=1.
- Throughput: one transfer per cycle in aggregate. Under continuous contention each port gets 1 transfer per 2 cycles.
- Reset asserted mid-read: the in-flight valid is discarded and never pulses after `reset_n` rises.
- `protect_violation` latency is 1 cycle after the blocked write's accept edge.

## Structure
- Package `controller_memory_pkg`: the `port_id_t` enum (PORT_S1, PORT_S2) and the latency constant function `read_latency(OUTPUT_REG)`.
- Sub-module `controller_spram`: inferred single-port, byte-enabled synchronous RAM with INIT_FILE and the optional output register. Arbitration, tag pipeline and protection logic stay in the top.

## Test plan
- Latency: OUTPUT_REG=0, write 0xDEADBEEF to address 0x0010 via s2 with debugaccess=1, then read it via s1. Required: `s1_readdatavalid` pulses exactly 1 cycle after accept with data 0xDEADBEEF. Repeat with OUTPUT_REG=1; the pulse must come 2 cycles after accept.
- Tie after reset: s1 and s2 both read on the first cycle after reset. Required: s1 is granted and s2 sees `waitrequest`=1 for 1 cycle. Under sustained contention the grants alternate s1, s2, s1, s2.
- Byte lanes: write 0xFFFFFFFF, then write 0x12345678 with byteenable=0b0101. Required: a subsequent read returns 0xFF34FF78.
- Protection: WRITE_PROTECT=1, s1 writes 0xAAAA5555 with debugaccess=0. Required: the contents are unchanged, `protect_violation` pulses once 1 cycle later, and `s1_waitrequest` stays 0.
- Valid routing: s1 reads address A while s2 reads address B in back-to-back accepted cycles. Required: each `readdatavalid` pulses only on its own port, in order, with the correct data.
- Reset mid-read: drop `reset_n` the cycle after a read is accepted. Required: no `readdatavalid` pulse, and all outputs read 0 while in reset.

Source files
------------

// File: rtl/controller_memory_pkg.sv
// ----------------------------------------------------------------------------
// controller_memory_pkg
// Shared definitions for the controller shared memory:
//   port_id_t     - identifies which slave port owns an access / read return
//   read_latency  - cycles from the accept edge to readdatavalid
// ----------------------------------------------------------------------------
package controller_memory_pkg;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_id_t;

    // One cycle for the array read register, plus one if the output
    // register stage is enabled.
    function automatic int read_latency(input int output_reg);
        return (output_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/controller_spram.sv
// ----------------------------------------------------------------------------
// controller_spram
// Single-port, byte-enabled synchronous RAM with optional output register.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (read registers only)
//   we, be        - write strobe and byte lanes
//   re            - read strobe
//   addr, wdata   - word address and write data
//   rdata         - read data (1 or 2 cycles after re), holds between reads
// The array itself is never reset; it keeps INIT_FILE or last-written data.
// ----------------------------------------------------------------------------
module controller_spram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 13,
    parameter int    OUTPUT_REG = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we,
    input  logic                      re,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_p0;
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic                  re_p0;

    // Array write port: only enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---- stage p0: array read register; p1: optional output register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_p0 <= '0;
            rdata_p1 <= '0;
            re_p0    <= 1'b0;
        end else begin
            re_p0 <= re;
            if (re) begin
                rdata_p0 <= mem[addr];
            end
            if (re_p0) begin
                rdata_p1 <= rdata_p0;
            end
        end
    end

    assign rdata = (OUTPUT_REG != 0) ? rdata_p1 : rdata_p0;

endmodule

// File: rtl/controller_shared_memory.sv
// ----------------------------------------------------------------------------
// controller_shared_memory
// One single-port RAM shared by two Avalon-MM slave ports with round-robin
// arbitration, pipelined reads and debugaccess-gated write protection.
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   sN_address/byteenable     - word address, write byte lanes
//   sN_read/write/writedata   - request strobes and write data
//   sN_debugaccess            - write qualifier when WRITE_PROTECT=1
//   sN_waitrequest            - request pending but not granted this cycle
//   sN_readdata/readdatavalid - shared read data, per-port valid pulse
//   protect_violation         - pulse one cycle after a blocked write
// ----------------------------------------------------------------------------
module controller_shared_memory
    import controller_memory_pkg::*;
#(
    parameter int    DATA_WIDTH    = 32,
    parameter int    ADDR_WIDTH    = 13,
    parameter int    OUTPUT_REG    = 0,
    parameter int    WRITE_PROTECT = 1,
    parameter string INIT_FILE     = "controller_shared_memory.hex"
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    input  logic                      s1_debugaccess,
    output logic                      s1_waitrequest,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    input  logic                      s2_debugaccess,
    output logic                      s2_waitrequest,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      protect_violation
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int LATENCY = read_latency(OUTPUT_REG);

    logic                  req_s1, req_s2;
    logic                  grant_s1, grant_s2, any_grant;
    port_id_t              last_grant;

    logic [ADDR_WIDTH-1:0] sel_address;
    logic [NB-1:0]         sel_byteenable;
    logic [DATA_WIDTH-1:0] sel_writedata;
    logic                  sel_read, sel_write, sel_debugaccess;
    logic                  wr_accept, rd_accept, wr_allowed;
    logic                  mem_we, wr_blocked;

    logic [LATENCY-1:0]    vld_pipe;
    port_id_t              tag_pipe [LATENCY];
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Round-robin: on a tie the port that did not win most recently goes.
    always_comb begin
        req_s1   = s1_read | s1_write;
        req_s2   = s2_read | s2_write;
        grant_s1 = 1'b0;
        grant_s2 = 1'b0;
        if (req_s1 && req_s2) begin
            if (last_grant == PORT_S2) grant_s1 = 1'b1;
            else                       grant_s2 = 1'b1;
        end else begin
            grant_s1 = req_s1;
            grant_s2 = req_s2;
        end
    end

    assign any_grant      = grant_s1 | grant_s2;
    assign s1_waitrequest = req_s1 & ~grant_s1;
    assign s2_waitrequest = req_s2 & ~grant_s2;

    // Granted port drives the array. read+write together counts as a write.
    always_comb begin
        sel_address     = grant_s2 ? s2_address     : s1_address;
        sel_byteenable  = grant_s2 ? s2_byteenable  : s1_byteenable;
        sel_writedata   = grant_s2 ? s2_writedata   : s1_writedata;
        sel_read        = grant_s2 ? s2_read        : s1_read;
        sel_write       = grant_s2 ? s2_write       : s1_write;
        sel_debugaccess = grant_s2 ? s2_debugaccess : s1_debugaccess;
        wr_accept       = any_grant & sel_write;
        rd_accept       = any_grant & sel_read & ~sel_write;
        wr_allowed      = (WRITE_PROTECT == 0) | sel_debugaccess;
        mem_we          = wr_accept & wr_allowed;
        wr_blocked      = wr_accept & ~wr_allowed;
    end

    controller_spram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUTPUT_REG (OUTPUT_REG),
        .INIT_FILE  (INIT_FILE)
    ) u_spram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .re      (rd_accept),
        .be      (sel_byteenable),
        .addr    (sel_address),
        .wdata   (sel_writedata),
        .rdata   (ram_rdata)
    );

    // ---- accept edge: arbiter history, valid/tag pipeline, violation flag ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant        <= PORT_S2;
            vld_pipe          <= '0;
            protect_violation <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= PORT_S1;
            end
        end else begin
            if (grant_s1)      last_grant <= PORT_S1;
            else if (grant_s2) last_grant <= PORT_S2;
            vld_pipe[0]       <= rd_accept;
            tag_pipe[0]       <= grant_s2 ? PORT_S2 : PORT_S1;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            protect_violation <= wr_blocked;
        end
    end

    // Data is shared; only the valid is steered by the returning tag.
    assign s1_readdatavalid = vld_pipe[LATENCY-1] & (tag_pipe[LATENCY-1] == PORT_S1);
    assign s2_readdatavalid = vld_pipe[LATENCY-1] & (tag_pipe[LATENCY-1] == PORT_S2);
    assign s1_readdata      = ram_rdata;
    assign s2_readdata      = ram_rdata;

endmodule

// File: tb/tb_controller_shared_memory.sv
// Bench for controller_shared_memory: two instances (OUTPUT_REG 0 and 1)
// share one stimulus stream and are checked against a transaction-level model.
module tb_controller_shared_memory;

    typedef struct {
        logic        rd, wr, dbg;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        req_t        p1, p2;
        logic        w1, w2;      // expected waitrequest before the edge
        logic        v1, v2;      // expected OUTPUT_REG=0 valids after the edge
        logic [31:0] rd;          // expected OUTPUT_REG=0 readdata after the edge
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [12:0] s1_address = '0, s2_address = '0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic        s1_read = 1'b0, s1_write = 1'b0, s1_debugaccess = 1'b0;
    logic        s2_read = 1'b0, s2_write = 1'b0, s2_debugaccess = 1'b0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    logic        s1_wr [2], s2_wr [2], s1_rdv [2], s2_rdv [2], pv [2];
    logic [31:0] s1_rd [2], s2_rd [2];

    always #5 clk = ~clk;

    controller_shared_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .OUTPUT_REG(0),
                               .WRITE_PROTECT(1), .INIT_FILE("")) dut0 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_debugaccess(s1_debugaccess),
        .s1_waitrequest(s1_wr[0]), .s1_readdata(s1_rd[0]), .s1_readdatavalid(s1_rdv[0]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_debugaccess(s2_debugaccess),
        .s2_waitrequest(s2_wr[0]), .s2_readdata(s2_rd[0]), .s2_readdatavalid(s2_rdv[0]),
        .protect_violation(pv[0]));

    controller_shared_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .OUTPUT_REG(1),
                               .WRITE_PROTECT(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_debugaccess(s1_debugaccess),
        .s1_waitrequest(s1_wr[1]), .s1_readdata(s1_rd[1]), .s1_readdatavalid(s1_rdv[1]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_debugaccess(s2_debugaccess),
        .s2_waitrequest(s2_wr[1]), .s2_readdata(s2_rd[1]), .s2_readdatavalid(s2_rdv[1]),
        .protect_violation(pv[1]));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word memory, round-robin history, and per-edge
    // records of what the spec says must come back and when.
    logic [31:0] mem_model [64];
    int          last_g = 2;
    int          edge_no = 0;
    int          rd_port [int];
    logic [31:0] rd_data [int];
    bit          pv_at   [int];
    logic [31:0] last_rd [2];

    logic        snap_w1 [2], snap_w2 [2], snap_v1 [2], snap_v2 [2], snap_pv [2];
    logic [31:0] snap_rd [2];

    vec_t tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input bit rd, input bit wr, input bit dbg,
                                input logic [12:0] a, input logic [3:0] be,
                                input logic [31:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.dbg = dbg; r.addr = a; r.be = be; r.wd = wd;
        return r;
    endfunction

    function automatic req_t idle();
        return mk(0, 0, 0, 13'd0, 4'd0, 32'd0);
    endfunction

    function automatic req_t rdq(input logic [12:0] a);
        return mk(1, 0, 0, a, 4'd0, 32'd0);
    endfunction

    function automatic req_t wrq(input logic [12:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input bit dbg);
        return mk(0, 1, dbg, a, be, d);
    endfunction

    task automatic reset_model();
        last_g = 2;
        rd_port.delete();
        rd_data.delete();
        pv_at.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic drive(input req_t p1, input req_t p2);
        s1_read = p1.rd; s1_write = p1.wr; s1_debugaccess = p1.dbg;
        s1_address = p1.addr; s1_byteenable = p1.be; s1_writedata = p1.wd;
        s2_read = p2.rd; s2_write = p2.wr; s2_debugaccess = p2.dbg;
        s2_address = p2.addr; s2_byteenable = p2.be; s2_writedata = p2.wd;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s dut%0d s1_waitrequest", tag, k), {31'd0, s1_wr[k]}, 32'd0);
            chk($sformatf("%s dut%0d s2_waitrequest", tag, k), {31'd0, s2_wr[k]}, 32'd0);
            chk($sformatf("%s dut%0d s1_readdatavalid", tag, k), {31'd0, s1_rdv[k]}, 32'd0);
            chk($sformatf("%s dut%0d s2_readdatavalid", tag, k), {31'd0, s2_rdv[k]}, 32'd0);
            chk($sformatf("%s dut%0d s1_readdata", tag, k), s1_rd[k], 32'd0);
            chk($sformatf("%s dut%0d s2_readdata", tag, k), s2_rd[k], 32'd0);
            chk($sformatf("%s dut%0d protect_violation", tag, k), {31'd0, pv[k]}, 32'd0);
        end
    endtask

    // Called at a negedge; holds reset for 'cycles' edges, releases at a negedge.
    task automatic do_reset(input int cycles);
        drive(idle(), idle());
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
    endtask

    // One bus cycle: drive at negedge, check waitrequest, model the edge,
    // check read returns / violation flag just after the edge.
    task automatic step(input req_t p1, input req_t p2, output int g);
        bit   q1, q2;
        int   e, ep;
        req_t r;
        assert (!(p1.rd && p1.wr)) else $error("s1 read and write asserted together");
        assert (!(p2.rd && p2.wr)) else $error("s2 read and write asserted together");
        drive(p1, p2);
        q1 = p1.rd | p1.wr;
        q2 = p2.rd | p2.wr;
        if (q1 && q2)  g = (last_g == 2) ? 1 : 2;
        else if (q1)   g = 1;
        else if (q2)   g = 2;
        else           g = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            snap_w1[k] = s1_wr[k];
            snap_w2[k] = s2_wr[k];
            chk($sformatf("dut%0d s1_waitrequest", k), {31'd0, s1_wr[k]}, {31'd0, q1 && g != 1});
            chk($sformatf("dut%0d s2_waitrequest", k), {31'd0, s2_wr[k]}, {31'd0, q2 && g != 2});
        end
        @(posedge clk);
        edge_no++;
        e = edge_no;
        if (g != 0) begin
            r = (g == 1) ? p1 : p2;
            last_g = g;
            if (r.wr) begin
                if (r.dbg) begin
                    for (int b = 0; b < 4; b++)
                        if (r.be[b]) mem_model[r.addr[5:0]][b*8 +: 8] = r.wd[b*8 +: 8];
                end else begin
                    pv_at[e] = 1'b1;
                end
            end else begin
                rd_port[e] = g;
                rd_data[e] = mem_model[r.addr[5:0]];
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            ep = rd_port.exists(e - k) ? rd_port[e - k] : 0;
            if (ep != 0) last_rd[k] = rd_data[e - k];
            snap_v1[k] = s1_rdv[k];
            snap_v2[k] = s2_rdv[k];
            snap_rd[k] = s1_rd[k];
            snap_pv[k] = pv[k];
            chk($sformatf("dut%0d s1_readdatavalid", k), {31'd0, s1_rdv[k]}, {31'd0, ep == 1});
            chk($sformatf("dut%0d s2_readdatavalid", k), {31'd0, s2_rdv[k]}, {31'd0, ep == 2});
            chk($sformatf("dut%0d s1_readdata", k), s1_rd[k], last_rd[k]);
            chk($sformatf("dut%0d s2_readdata", k), s2_rd[k], last_rd[k]);
            chk($sformatf("dut%0d protect_violation", k), {31'd0, pv[k]}, {31'd0, pv_at.exists(e)});
        end
        @(negedge clk);
    endtask

    task automatic set_row(input int i, input req_t p1, input req_t p2, input logic w1,
                           input logic w2, input logic v1, input logic v2, input logic [31:0] rd);
        tab[i].p1 = p1; tab[i].p2 = p2; tab[i].w1 = w1; tab[i].w2 = w2;
        tab[i].v1 = v1; tab[i].v2 = v2; tab[i].rd = rd;
    endtask

    function automatic req_t rand_req();
        logic [12:0] a;
        a = 13'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0) return rdq(a);
        return wrq(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   g;
        req_t pend1, pend2;
        bit   has1, has2;

        // Tie/sustained contention, byte lanes; run right after a reset.
        set_row(0, rdq(13'h10), rdq(13'h20), 0, 1, 1, 0, 32'hDEADBEEF);
        set_row(1, rdq(13'h11), rdq(13'h20), 1, 0, 0, 1, 32'hC0DE0020);
        set_row(2, rdq(13'h11), rdq(13'h21), 0, 1, 1, 0, 32'hC0DE0011);
        set_row(3, rdq(13'h12), rdq(13'h21), 1, 0, 0, 1, 32'hC0DE0021);
        set_row(4, rdq(13'h12), idle(),      0, 0, 1, 0, 32'hC0DE0012);
        set_row(5, idle(), wrq(13'h22, 32'hFFFFFFFF, 4'hF, 1), 0, 0, 0, 0, 32'hC0DE0012);
        set_row(6, idle(), wrq(13'h22, 32'h12345678, 4'h5, 1), 0, 0, 0, 0, 32'hC0DE0012);
        set_row(7, rdq(13'h22), idle(),      0, 0, 1, 0, 32'hFF34FF78);
        set_row(8, idle(), idle(),           0, 0, 0, 0, 32'hFF34FF78);
        set_row(9, idle(), idle(),           0, 0, 0, 0, 32'hFF34FF78);

        #2;
        do_reset(3);

        for (int a = 0; a < 64; a++)
            step(idle(), wrq(13'(a), 32'hC0DE0000 | 32'(a), 4'hF, 1), g);

        // Latency: write then read the next cycle.
        step(idle(), wrq(13'h10, 32'hDEADBEEF, 4'hF, 1), g);
        step(rdq(13'h10), idle(), g);
        chk("lat0 valid after 1", {31'd0, snap_v1[0]}, 32'd1);
        chk("lat0 data", snap_rd[0], 32'hDEADBEEF);
        chk("lat1 no valid after 1", {31'd0, snap_v1[1]}, 32'd0);
        step(idle(), idle(), g);
        chk("lat0 single pulse", {31'd0, snap_v1[0]}, 32'd0);
        chk("lat1 valid after 2", {31'd0, snap_v1[1]}, 32'd1);
        chk("lat1 data", snap_rd[1], 32'hDEADBEEF);

        // Valid routing: s1 then s2 back-to-back.
        step(rdq(13'h05), idle(), g);
        chk("route0 s1 v", {31'd0, snap_v1[0]}, 32'd1);
        chk("route0 s2 quiet", {31'd0, snap_v2[0]}, 32'd0);
        chk("route0 dataA", snap_rd[0], 32'hC0DE0005);
        step(idle(), rdq(13'h06), g);
        chk("route0 s1 quiet", {31'd0, snap_v1[0]}, 32'd0);
        chk("route0 s2 v", {31'd0, snap_v2[0]}, 32'd1);
        chk("route0 dataB", snap_rd[0], 32'hC0DE0006);
        chk("route1 s1 v", {31'd0, snap_v1[1]}, 32'd1);
        chk("route1 dataA", snap_rd[1], 32'hC0DE0005);
        step(idle(), idle(), g);
        chk("route1 s1 quiet", {31'd0, snap_v1[1]}, 32'd0);
        chk("route1 s2 v", {31'd0, snap_v2[1]}, 32'd1);
        chk("route1 dataB", snap_rd[1], 32'hC0DE0006);

        // Table: tie after reset, alternation, byte lanes.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(tab[i].p1, tab[i].p2, g);
            chk($sformatf("tab%0d s1_waitrequest", i), {31'd0, snap_w1[0]}, {31'd0, tab[i].w1});
            chk($sformatf("tab%0d s2_waitrequest", i), {31'd0, snap_w2[0]}, {31'd0, tab[i].w2});
            chk($sformatf("tab%0d s1_readdatavalid", i), {31'd0, snap_v1[0]}, {31'd0, tab[i].v1});
            chk($sformatf("tab%0d s2_readdatavalid", i), {31'd0, snap_v2[0]}, {31'd0, tab[i].v2});
            chk($sformatf("tab%0d readdata", i), snap_rd[0], tab[i].rd);
        end

        // Protection: blocked write is accepted, flagged once, changes nothing.
        step(wrq(13'h22, 32'hAAAA5555, 4'hF, 0), idle(), g);
        chk("prot0 s1_waitrequest", {31'd0, snap_w1[0]}, 32'd0);
        chk("prot1 s1_waitrequest", {31'd0, snap_w1[1]}, 32'd0);
        chk("prot0 violation pulse", {31'd0, snap_pv[0]}, 32'd1);
        chk("prot1 violation pulse", {31'd0, snap_pv[1]}, 32'd1);
        step(rdq(13'h22), idle(), g);
        chk("prot0 violation once", {31'd0, snap_pv[0]}, 32'd0);
        chk("prot0 contents kept", snap_rd[0], 32'hFF34FF78);
        step(idle(), idle(), g);
        chk("prot1 contents kept", snap_rd[1], 32'hFF34FF78);

        // Reset right after a read is accepted.
        drive(rdq(13'h07), idle());
        #1;
        chk("midrst s1_waitrequest", {31'd0, s1_wr[0]}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(idle(), idle());
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
        for (int i = 0; i < 3; i++) step(idle(), idle(), g);

        // Random traffic; a losing port holds its request until granted.
        has1 = 0;
        has2 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!has1 && $urandom_range(0, 9) < 6) begin pend1 = rand_req(); has1 = 1; end
            if (!has2 && $urandom_range(0, 9) < 6) begin pend2 = rand_req(); has2 = 1; end
            step(has1 ? pend1 : idle(), has2 ? pend2 : idle(), g);
            if (g == 1) has1 = 0;
            if (g == 2) has2 = 0;
        end
        for (int i = 0; i < 3; i++) step(idle(), idle(), g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
